gb_cart_header_loader: RTL and testbench

- Boot-time reader that scans the cartridge header from external ROM memory before the CPU is released.
- Publishes cart_type, rom_size, ram_size and cgb to the memory bank controllers.
- Verifies the header checksum and holds the CPU until the scan completes.
- Acts as the initiator on the external memory read port. It drives the same 24-bit physical address space that the MBC address output targets.

---
 rtl/gb_cart_header_loader_if.sv | 11 +
 rtl/gb_cart_header_loader.sv | 141 ++++++++++++++
 tb/tb_gb_cart_header_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_cart_header_loader_if.sv
// External ROM read port used by the cartridge header loader.
// The loader is the master; the memory responder is the slave.
interface gb_cart_header_loader_if;
  logic [23:0] addr_bus_out;
  logic        rd_req;
  logic        rd_ack;
  logic [7:0]  data_in;

  modport master (output addr_bus_out, rd_req, input rd_ack, data_in);
  modport slave  (input addr_bus_out, rd_req, output rd_ack, data_in);
endinterface

// File: rtl/gb_cart_header_loader.sv
// Boot-time cartridge header scanner: reads ROM bytes 0x134..0x14D, publishes
// the MBC-relevant fields, verifies the header checksum and gates the CPU reset.
module gb_cart_header_loader #(
  parameter logic [23:0] ROM_BASE       = 24'h000000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter bit          STRICT         = 1'b1
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           rescan,
  gb_cart_header_loader_if.master        mem,
  output logic [7:0]                     cart_type,
  output logic [7:0]                     rom_size,
  output logic [7:0]                     ram_size,
  output logic                           cgb,
  output logic                           header_ok,
  output logic                           timeout,
  output logic                           done,
  output logic                           cpu_hold
);

  typedef enum logic [2:0] {IDLE, REQ, GAP, CHECK, DONE, ERROR} state_t;

  localparam logic [8:0] OFF_FIRST = 9'h134;
  localparam logic [8:0] OFF_CGB   = 9'h143;
  localparam logic [8:0] OFF_CART  = 9'h147;
  localparam logic [8:0] OFF_ROM   = 9'h148;
  localparam logic [8:0] OFF_RAM   = 9'h149;
  localparam logic [8:0] OFF_LAST  = 9'h14D;

  state_t      state, state_next;
  logic [8:0]  offset, offset_next;
  logic [7:0]  chk;
  logic [7:0]  byte14d;
  logic [15:0] tmo_cnt;
  logic [23:0] addr_q;
  logic        rd_req_q;
  logic        consume;
  logic        tmo_hit;

  assign mem.addr_bus_out = addr_q;
  assign mem.rd_req       = rd_req_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    offset_next = offset;
    consume     = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      IDLE: begin
        state_next  = REQ;
        offset_next = OFF_FIRST;
      end
      REQ: begin
        if (mem.rd_ack) begin
          consume    = 1'b1;
          // The cycle spent in CHECK doubles as the gap after the last byte.
          state_next = (offset == OFF_LAST) ? CHECK : GAP;
        end else if (TIMEOUT_CYCLES != 16'd0 && tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
          tmo_hit    = 1'b1;
          state_next = ERROR;
        end
      end
      GAP: begin
        state_next  = REQ;
        offset_next = offset + 9'd1;
      end
      CHECK:       state_next = DONE;
      DONE, ERROR: if (rescan) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      offset    <= '0;
      chk       <= '0;
      byte14d   <= '0;
      tmo_cnt   <= '0;
      addr_q    <= '0;
      rd_req_q  <= 1'b0;
      cart_type <= '0;
      rom_size  <= '0;
      ram_size  <= '0;
      cgb       <= 1'b0;
      header_ok <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      offset   <= offset_next;
      tmo_cnt  <= (state == REQ && state_next == REQ) ? tmo_cnt + 16'd1 : 16'd0;
      rd_req_q <= (state_next == REQ);
      if (state_next == REQ) addr_q <= ROM_BASE + {15'd0, offset_next};
      if (state == IDLE) chk <= '0;

      if (consume) begin
        if (offset == OFF_LAST) byte14d <= mem.data_in;
        else                    chk     <= chk - mem.data_in - 8'd1;
        case (offset)
          OFF_CGB:  cgb       <= mem.data_in[7];
          OFF_CART: cart_type <= mem.data_in;
          OFF_ROM:  rom_size  <= mem.data_in;
          OFF_RAM:  ram_size  <= mem.data_in;
          default:  ;
        endcase
      end

      if (state == CHECK) begin
        header_ok <= (byte14d == chk);
        done      <= 1'b1;
        cpu_hold  <= STRICT && (byte14d != chk);
      end

      if (tmo_hit) begin
        timeout   <= 1'b1;
        header_ok <= 1'b0;
        done      <= 1'b1;
        cpu_hold  <= STRICT;
      end

      // Cart swap: drop everything published and hold the CPU again.
      if ((state == DONE || state == ERROR) && rescan) begin
        cart_type <= '0;
        rom_size  <= '0;
        ram_size  <= '0;
        cgb       <= 1'b0;
        header_ok <= 1'b0;
        timeout   <= 1'b0;
        done      <= 1'b0;
        cpu_hold  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gb_cart_header_loader.sv
// Directed bench for gb_cart_header_loader: four parameterisations, a ROM
// responder, a header-checksum model and a per-cycle compare process.
module tb_gb_cart_header_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [3:0] rst_v;
  logic       rescan_drv;
  logic       ack_drv;
  logic [7:0] dat_drv;
  int         act;

  gb_cart_header_loader_if m0 ();
  gb_cart_header_loader_if m1 ();
  gb_cart_header_loader_if m2 ();
  gb_cart_header_loader_if m3 ();

  assign m0.rd_ack = ack_drv && (act == 0);
  assign m1.rd_ack = ack_drv && (act == 1);
  assign m2.rd_ack = ack_drv && (act == 2);
  assign m3.rd_ack = ack_drv && (act == 3);
  assign m0.data_in = dat_drv;
  assign m1.data_in = dat_drv;
  assign m2.data_in = dat_drv;
  assign m3.data_in = dat_drv;

  logic [23:0] o_addr [4];
  logic        o_req  [4];
  logic [7:0]  o_cart [4];
  logic [7:0]  o_rom  [4];
  logic [7:0]  o_ram  [4];
  logic        o_cgb  [4];
  logic        o_ok   [4];
  logic        o_tmo  [4];
  logic        o_done [4];
  logic        o_hold [4];

  assign o_addr[0] = m0.addr_bus_out;  assign o_req[0] = m0.rd_req;
  assign o_addr[1] = m1.addr_bus_out;  assign o_req[1] = m1.rd_req;
  assign o_addr[2] = m2.addr_bus_out;  assign o_req[2] = m2.rd_req;
  assign o_addr[3] = m3.addr_bus_out;  assign o_req[3] = m3.rd_req;

  gb_cart_header_loader u0 (
    .clock(clock), .rst(rst_v[0]), .rescan(rescan_drv && act == 0), .mem(m0),
    .cart_type(o_cart[0]), .rom_size(o_rom[0]), .ram_size(o_ram[0]), .cgb(o_cgb[0]),
    .header_ok(o_ok[0]), .timeout(o_tmo[0]), .done(o_done[0]), .cpu_hold(o_hold[0]));

  gb_cart_header_loader #(.TIMEOUT_CYCLES(16'd8), .STRICT(1'b1)) u1 (
    .clock(clock), .rst(rst_v[1]), .rescan(rescan_drv && act == 1), .mem(m1),
    .cart_type(o_cart[1]), .rom_size(o_rom[1]), .ram_size(o_ram[1]), .cgb(o_cgb[1]),
    .header_ok(o_ok[1]), .timeout(o_tmo[1]), .done(o_done[1]), .cpu_hold(o_hold[1]));

  gb_cart_header_loader #(.TIMEOUT_CYCLES(16'd8), .STRICT(1'b0)) u2 (
    .clock(clock), .rst(rst_v[2]), .rescan(rescan_drv && act == 2), .mem(m2),
    .cart_type(o_cart[2]), .rom_size(o_rom[2]), .ram_size(o_ram[2]), .cgb(o_cgb[2]),
    .header_ok(o_ok[2]), .timeout(o_tmo[2]), .done(o_done[2]), .cpu_hold(o_hold[2]));

  gb_cart_header_loader #(.ROM_BASE(24'h100000)) u3 (
    .clock(clock), .rst(rst_v[3]), .rescan(rescan_drv && act == 3), .mem(m3),
    .cart_type(o_cart[3]), .rom_size(o_rom[3]), .ram_size(o_ram[3]), .cgb(o_cgb[3]),
    .header_ok(o_ok[3]), .timeout(o_tmo[3]), .done(o_done[3]), .cpu_hold(o_hold[3]));

  // Signals of the instance currently under test.
  logic [23:0] c_addr, c_base;
  logic [7:0]  c_cart, c_rom, c_ram;
  logic        c_req, c_cgb, c_ok, c_tmo, c_done, c_hold, c_rst;

  always_comb begin
    c_addr = o_addr[act[1:0]];
    c_req  = o_req[act[1:0]];
    c_cart = o_cart[act[1:0]];
    c_rom  = o_rom[act[1:0]];
    c_ram  = o_ram[act[1:0]];
    c_cgb  = o_cgb[act[1:0]];
    c_ok   = o_ok[act[1:0]];
    c_tmo  = o_tmo[act[1:0]];
    c_done = o_done[act[1:0]];
    c_hold = o_hold[act[1:0]];
    c_rst  = rst_v[act[1:0]];
    c_base = (act == 3) ? 24'h100000 : 24'h000000;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Header image for offsets 0x134..0x14D, index = offset - 0x134.
  logic [7:0] img [26];
  int stall_idx;
  int delay;
  bit noisy;

  logic [7:0] e_cart, e_rom, e_ram;
  logic       e_cgb, e_ok, e_tmo, e_hold;
  int         e_reqs;

  // Expected result of one scan: header checksum is -(sum of bytes + count).
  task automatic model_scan(input bit strict);
    int   sum;
    bit   stalled;
    logic [7:0] cs;
    sum = 0; stalled = 0;
    e_cart = 0; e_rom = 0; e_ram = 0; e_cgb = 0; e_reqs = 0;
    for (int i = 0; i < 26; i++) begin
      if (!stalled) begin
        e_reqs++;
        if (i == stall_idx) stalled = 1;
        else begin
          if (i < 25) sum += int'(img[i]);
          if (i == 15) e_cgb  = img[i][7];
          if (i == 19) e_cart = img[i];
          if (i == 20) e_rom  = img[i];
          if (i == 21) e_ram  = img[i];
        end
      end
    end
    cs = 8'(0 - sum - 25);
    if (stalled) begin
      e_tmo = 1; e_ok = 0; e_hold = strict;
    end else begin
      e_tmo = 0; e_ok = (img[25] == cs); e_hold = strict && !e_ok;
    end
  endtask

  task automatic set_base_image();
    for (int i = 0; i < 26; i++) img[i] = 8'h00;
    img[25] = 8'hE7;
  endtask

  // ROM responder: acks after `delay` wait cycles, random data otherwise.
  initial begin
    int wcnt;
    int idx;
    ack_drv = 1'b0;
    dat_drv = 8'h00;
    wcnt = 0;
    forever begin
      @(negedge clock);
      if (c_rst && c_req) begin
        wcnt++;
        idx = int'(c_addr - c_base) - 'h134;
        if (idx != stall_idx && wcnt > delay && idx >= 0 && idx < 26) begin
          ack_drv = 1'b1;
          dat_drv = img[idx];
        end else begin
          ack_drv = 1'b0;
          dat_drv = 8'($urandom);
        end
      end else begin
        wcnt    = 0;
        ack_drv = noisy ? 1'($urandom) : 1'b0;
        dat_drv = 8'($urandom);
      end
    end
  end

  int cyc, reqs, gap_len, hi_len, last_hi, done_cyc;
  bit prev_req, saw_done;
  logic [23:0] prev_addr;

  // Compare process: protocol shape every cycle, results when done rises.
  initial begin
    cyc = 0; reqs = 0; gap_len = 0; hi_len = 0; last_hi = 0; done_cyc = 0;
    prev_req = 0; saw_done = 0; prev_addr = '0;
    forever begin
      @(negedge clock);
      if (!c_rst) begin
        check("reset_state", {c_addr, c_req, c_cart, c_rom, c_ram, c_cgb, c_ok, c_tmo, c_done, c_hold},
              {24'h0, 1'b0, 24'h0, 4'b0000, 1'b1});
        cyc = 0; reqs = 0; gap_len = 0; hi_len = 0; prev_req = 0; saw_done = 0;
      end else begin
        cyc++;
        if (saw_done && !c_done) begin
          saw_done = 0; reqs = 0; gap_len = 0; hi_len = 0; prev_req = 0;
        end
        if (!saw_done) begin
          if (c_req) begin
            hi_len++;
            if (prev_req) check("addr_stable", c_addr, prev_addr);
            else begin
              check("req_addr", c_addr, 24'(c_base + 24'h134 + 24'(reqs)));
              if (reqs > 0) check("gap_len", gap_len, 1);
              reqs++;
            end
            gap_len = 0;
          end else begin
            if (prev_req) last_hi = hi_len;
            hi_len = 0;
            gap_len++;
          end
          if (c_done) begin
            saw_done = 1;
            done_cyc = cyc;
            check("final_outputs", {c_cart, c_rom, c_ram, c_cgb, c_ok, c_tmo, c_hold},
                  {e_cart, e_rom, e_ram, e_cgb, e_ok, e_tmo, e_hold});
            check("req_count", reqs, e_reqs);
          end else begin
            check("scan_flags", {c_ok, c_tmo, c_hold}, 3'b001);
          end
        end else begin
          check("done_held", c_done, 1);
        end
        prev_req  = c_req;
        prev_addr = c_addr;
      end
    end
  end

  task automatic start_scan(input int a);
    @(negedge clock);
    #2 rst_v = 4'b0000;
    act = a;
    repeat (2) @(negedge clock);
    #2 rst_v[a] = 1'b1;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!c_done && n < maxc) begin
      @(negedge clock);
      n++;
    end
    #1 check("done_reached", c_done, 1);
  endtask

  task automatic wait_req(input int maxc);
    int n;
    n = 0;
    while (!c_req && n < maxc) begin
      @(negedge clock);
      n++;
    end
    #1 check("req_reached", c_req, 1);
  endtask

  initial begin
    rst_v = 4'b0000; rescan_drv = 1'b0; act = 0;
    delay = 0; noisy = 0; stall_idx = -1;

    // Blank header, zero-wait memory.
    set_base_image();
    model_scan(1'b1);
    repeat (3) @(negedge clock);
    #2 rst_v[0] = 1'b1;
    wait_done(200);
    check("t1_done_cycle", done_cyc, 53);
    check("t1_ok_hold_done", {c_ok, c_hold, c_done}, 3'b101);
    check("t1_sizes", {c_cart, c_rom, c_ram, c_cgb}, 25'h0);

    // MBC1 with 64 KiB ROM, good then corrupted checksum.
    img[19] = 8'h01; img[20] = 8'h01; img[25] = 8'hE5;
    model_scan(1'b1);
    start_scan(0);
    wait_done(200);
    check("t2_fields", {c_cart, c_rom, c_ok, c_hold}, {8'h01, 8'h01, 1'b1, 1'b0});
    img[25] = 8'hE6;
    model_scan(1'b1);
    start_scan(0);
    wait_done(200);
    check("t2_bad_sum", {c_ok, c_hold, c_done}, 3'b011);

    // Slow memory with noise on the bus between acks; CGB flag set.
    set_base_image();
    img[15] = 8'h80; img[25] = 8'h67;
    delay = 3; noisy = 1;
    model_scan(1'b1);
    start_scan(0);
    wait_done(600);
    check("t3_cgb_ok", {c_cgb, c_ok, c_hold}, 3'b110);
    delay = 0; noisy = 0;

    // Memory never answers 0x140.
    set_base_image();
    stall_idx = 12;
    model_scan(1'b1);
    start_scan(1);
    wait_done(200);
    check("t4_stall_len", last_hi, 8);
    check("t4_strict", {c_tmo, c_done, c_ok, c_hold}, 4'b1101);
    model_scan(1'b0);
    start_scan(2);
    wait_done(200);
    check("t4_lenient", {c_tmo, c_done, c_hold}, 3'b110);
    stall_idx = -1;

    // Reset pulse while reading 0x148, after cart_type is already loaded.
    set_base_image();
    img[19] = 8'h01; img[25] = 8'hE6;
    model_scan(1'b1);
    start_scan(0);
    begin
      int n;
      n = 0;
      while (!(c_req && c_addr == 24'h000148) && n < 200) begin
        @(negedge clock);
        n++;
      end
    end
    check("t5_reached_148", c_addr, 24'h000148);
    check("t5_partial_cart", c_cart, 8'h01);
    #2 rst_v[0] = 1'b0;
    #1 check("t5_async_clear", {c_addr, c_req, c_cart, c_done, c_hold},
             {24'h0, 1'b0, 8'h00, 1'b0, 1'b1});
    @(negedge clock);
    #2 rst_v[0] = 1'b1;
    wait_req(10);
    check("t5_restart_addr", c_addr, 24'h000134);
    wait_done(200);
    check("t5_result", {c_cart, c_ok, c_hold}, {8'h01, 1'b1, 1'b0});

    // Relocated ROM, rescan ignored mid-scan, honoured after done.
    set_base_image();
    model_scan(1'b1);
    start_scan(3);
    repeat (10) @(negedge clock);
    #2 rescan_drv = 1'b1;
    @(negedge clock);
    #2 rescan_drv = 1'b0;
    wait_done(200);
    check("t6_first_scan", {c_ok, c_hold, c_ram}, {1'b1, 1'b0, 8'h00});
    img[21] = 8'h03; img[25] = 8'hE4;
    model_scan(1'b1);
    @(negedge clock);
    #2 rescan_drv = 1'b1;
    @(negedge clock);
    #1 check("t6_rescan_clear", {c_done, c_hold, c_ok, c_cart, c_ram}, {3'b010, 8'h00, 8'h00});
    #1 rescan_drv = 1'b0;
    wait_req(10);
    check("t6_first_addr", c_addr, 24'h100134);
    wait_done(200);
    check("t6_ram_size", {c_ram, c_ok, c_hold}, {8'h03, 1'b1, 1'b0});

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
